// File: rtl/execute_pkg.sv
// Execute-stage shared types: multiply/divide opcodes, muldiv FSM states and opcode decode helpers.
package execute_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Unsigned 1-bit/cycle restoring divider; the first iteration runs on the start edge,
// so done pulses WIDTH-1 cycles after start with raw quotient/remainder.
module muldiv_div_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;

    logic [WIDTH-1:0] src_rem, src_quo, src_div;
    logic [WIDTH:0]   shifted, diff;
    logic             step_ok;

    // Dividend bits shift out of quo while quotient bits shift in behind them.
    always_comb begin
        src_rem  = start_i ? '0 : rem_q;
        src_quo  = start_i ? dividend_i : quo_q;
        src_div  = start_i ? divisor_i : div_q;
        shifted  = {src_rem, src_quo[WIDTH-1]};
        diff     = shifted - {1'b0, src_div};
        step_ok  = (shifted >= {1'b0, src_div});

        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        done_d   = 1'b0;

        if (clear_i) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (start_i || active_q) begin
            rem_d = step_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            quo_d = {src_quo[WIDTH-2:0], step_ok};
            div_d = src_div;
            cnt_d = start_i ? CNT_W'(1) : cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(WIDTH)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end else begin
                active_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
        end
    end

    assign done_o      = done_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage multiply/divide unit: MULT/MULTU through a delay chain, DIV/DIVU through
// the restoring core, with valid/ready handshakes and flush abort.
module muldiv_unit
    import execute_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_STAGES = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int unsigned PW       = 2 * WIDTH;
    localparam int unsigned CHAIN    = (MULT_STAGES > 1) ? MULT_STAGES - 1 : 1;
    localparam int unsigned MCNT_W   = $clog2(MULT_STAGES + 1);
    localparam int unsigned MUL_LAST = (MULT_STAGES > 1) ? MULT_STAGES - 2 : 0;

    function automatic logic [PW-1:0] mul_full(input logic sgn,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic signed [PW+1:0] ea, eb;
        ea = (PW+2)'($signed({sgn & a[WIDTH-1], a}));
        eb = (PW+2)'($signed({sgn & b[WIDTH-1], b}));
        return PW'(ea * eb);
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic sgn, input logic [WIDTH-1:0] x);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    muldiv_state_t    state_q, state_d, launch_state;
    muldiv_op_t       op_c;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;
    logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic             resp_valid_q, busy_q;
    logic [PW-1:0]    chain_q [CHAIN];
    logic [PW-1:0]    prod_c, mul_tail_c;
    logic             accept_c, sgn_c, b_zero_c, take_launch, launch_load;
    logic [WIDTH-1:0] launch_hi, launch_lo;
    logic             core_start_c, core_done;
    logic [WIDTH-1:0] core_quo, core_rem, quo_fix_c, rem_fix_c;

    assign op_c      = muldiv_op_t'(req_op);
    assign sgn_c     = op_is_signed(op_c);
    assign b_zero_c  = (req_b == '0);
    assign req_ready = ~flush & ((state_q == IDLE) | ((state_q == DONE) & resp_ready));
    assign accept_c  = req_valid & req_ready;
    assign prod_c    = mul_full(sgn_c, req_a, req_b);

    assign core_start_c = accept_c & op_is_div(op_c) & ~b_zero_c;

    muldiv_div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk         (clk),
        .resetn      (resetn),
        .clear_i     (flush),
        .start_i     (core_start_c),
        .dividend_i  (mag(sgn_c, req_a)),
        .divisor_i   (mag(sgn_c, req_b)),
        .done_o      (core_done),
        .quotient_o  (core_quo),
        .remainder_o (core_rem)
    );

    assign quo_fix_c = neg_quo_q ? -core_quo : core_quo;
    assign rem_fix_c = neg_rem_q ? -core_rem : core_rem;

    // Product is captured on accept and only shifted afterwards; its tail feeds hi/lo.
    always_ff @(posedge clk) begin
        if (accept_c) chain_q[0] <= prod_c;
        for (int unsigned i = 1; i < CHAIN; i++) chain_q[i] <= chain_q[i-1];
    end

    generate
        if (MULT_STAGES > 1) begin : g_tail_chain
            assign mul_tail_c = chain_q[CHAIN-1];
        end else begin : g_tail_direct
            assign mul_tail_c = prod_c;
        end
    endgenerate

    // Where an accepted request goes, and whether it completes on the accept edge.
    always_comb begin
        launch_state = MUL;
        launch_load  = 1'b0;
        launch_hi    = req_a;
        launch_lo    = '1;
        if (op_is_div(op_c)) begin
            if (b_zero_c) begin
                launch_state = DONE;
                launch_load  = 1'b1;
            end else begin
                launch_state = DIV;
            end
        end else if (MULT_STAGES == 1) begin
            launch_state = DONE;
            launch_load  = 1'b1;
            launch_hi    = prod_c[PW-1:WIDTH];
            launch_lo    = prod_c[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        mcnt_d      = '0;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        take_launch = 1'b0;

        case (state_q)
            IDLE: take_launch = accept_c;
            MUL: begin
                if (mcnt_q == MCNT_W'(MUL_LAST)) begin
                    state_d = DONE;
                    hi_d    = mul_tail_c[PW-1:WIDTH];
                    lo_d    = mul_tail_c[WIDTH-1:0];
                end else begin
                    mcnt_d = mcnt_q + MCNT_W'(1);
                end
            end
            DIV: begin
                if (core_done) begin
                    state_d = DONE;
                    hi_d    = rem_fix_c;
                    lo_d    = quo_fix_c;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    if (accept_c) take_launch = 1'b1;
                    else          state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take_launch) begin
            state_d   = launch_state;
            neg_quo_d = sgn_c & (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
            neg_rem_d = sgn_c & req_a[WIDTH-1];
            if (launch_load) begin
                hi_d = launch_hi;
                lo_d = launch_lo;
            end
        end

        // Flush beats any same-cycle launch or completion; results keep their last value.
        if (flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            mcnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            hi_q         <= '0;
            lo_q         <= '0;
            mcnt_q       <= '0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            mcnt_q       <= mcnt_d;
            neg_quo_q    <= neg_quo_d;
            neg_rem_q    <= neg_rem_d;
            resp_valid_q <= (state_d == DONE);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign hi         = hi_q;
    assign lo         = lo_q;
    assign resp_valid = resp_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expected hi/lo/latency,
// a negedge monitor pops and compares on every response handshake.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_a = '0, req_b = '0;
    logic        resp_valid;
    logic        rdy = 1'b1;
    logic [31:0] hi, lo;
    logic        busy;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0, n_bad = 0;
    int          cyc = 0;
    bit          in_resp = 0;
    int          resp_start = 0;
    logic [31:0] last_hi = '0, last_lo = '0;
    bit          rand_rdy = 0;

    muldiv_unit #(.WIDTH(32), .MULT_STAGES(3)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (rdy),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference model, independent of the RTL structure.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output int lat);
        longint      sa, sb;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        h = '0; l = '0; lat = 3;
        case (op)
            2'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
            2'd1: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    h = a; l = 32'hFFFF_FFFF; lat = 1;
                end else begin
                    lat = 33;
                    if (op == 2'd3) begin
                        l = a / b; h = a % b;
                    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        l = 32'h8000_0000; h = 32'd0;
                    end else begin
                        l = 32'(ia / ib); h = 32'(ia % ib);
                    end
                end
            end
        endcase
    endfunction

    // Response monitor: latency is measured from the first cycle resp_valid is seen.
    always @(negedge clk) begin
        if (resetn && resp_valid) begin
            if (!in_resp) begin
                in_resp    = 1;
                resp_start = cyc;
            end
            if (rdy) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 64'(resp_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("resp_hi", 64'(hi), 64'(e.hi));
                    chk("resp_lo", 64'(lo), 64'(e.lo));
                    chk("resp_latency", 64'(resp_start - e.acc + 1), 64'(e.lat));
                    last_hi = e.hi;
                    last_lo = e.lo;
                end
                in_resp = 0;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 rdy = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] eh, input logic [31:0] el,
                         input int lat, input bit set_rdy, output bit in_done);
        bit   got;
        exp_t e;
        got     = 0;
        in_done = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        if (set_rdy) rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin got = 1; break; end
        end
        if (!got) begin
            n_vec++; n_bad++;
            $display("FAIL issue_timeout: req_ready stayed 0 for op %0d", op);
        end else begin
            in_done = resp_valid;
            if (push) begin
                e.hi = eh; e.lo = el; e.acc = cyc + 1; e.lat = lat;
                q.push_back(e);
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q.size());
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        bit          d;
        bit          saw;
        logic [1:0]  op;
        logic [31:0] a, b, eh, el;
        int          lat;

        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 3, 0, d);
        issue(2'd0, 32'hFFFF_FFFE, 32'd3, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 3, 0, d);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0, d);
        issue(2'd3, 32'd100, 32'd7, 1, 32'd2, 32'd14, 33, 0, d);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'h8000_0000, 33, 0, d);
        issue(2'd3, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1, 0, d);
        issue(2'd2, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1, 0, d);
        issue(2'd2, 32'd7, 32'hFFFF_FFFE, 1, 32'd1, 32'hFFFF_FFFD, 33, 0, d);
        drain();

        // Stall the consumer on a finished result, then release it alongside a new request.
        @(posedge clk); #1 rdy = 1'b0;
        issue(2'd1, 32'd7, 32'd9, 1, 32'd0, 32'd63, 3, 0, d);
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("stall_resp_valid", 64'(resp_valid), 64'd1);
        chk("stall_req_ready", 64'(req_ready), 64'd0);
        chk("stall_hi", 64'(hi), 64'd0);
        chk("stall_lo", 64'(lo), 64'd63);
        issue(2'd3, 32'd100, 32'd7, 1, 32'd2, 32'd14, 33, 1, d);
        chk("b2b_accept_in_done", 64'(d), 64'd1);
        drain();

        // Flush mid-divide.
        issue(2'd3, 32'd1000, 32'd3, 0, 32'd0, 32'd0, 0, 0, d);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_resp_valid", 64'(resp_valid), 64'd0);
        chk("flush_hi_hold", 64'(hi), 64'(last_hi));
        chk("flush_lo_hold", 64'(lo), 64'(last_lo));
        saw = 0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid) saw = 1;
        end
        chk("flush_no_resp", 64'(saw), 64'd0);

        // Flush blocks a same-cycle request.
        @(posedge clk); #1;
        flush = 1'b1; req_valid = 1'b1; req_op = 2'd1; req_a = 32'd1; req_b = 32'd1;
        @(negedge clk);
        chk("flush_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("flush_drop_busy", 64'(busy), 64'd0);

        issue(2'd1, 32'd2, 32'd3, 1, 32'd0, 32'd6, 3, 0, d);
        drain();

        // Reset mid-multiply.
        issue(2'd1, 32'd5, 32'd5, 0, 32'd0, 32'd0, 0, 0, d);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rstmid_hi", 64'(hi), 64'd0);
        chk("rstmid_lo", 64'(lo), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_req_ready", 64'(req_ready), 64'd1);
        chk("rstmid_resp_valid", 64'(resp_valid), 64'd0);

        // Randomised operations against the reference model, with consumer back-pressure.
        rand_rdy = 1;
        for (int k = 0; k < 300; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            model(op, a, b, eh, el, lat);
            issue(op, a, b, 1, eh, el, lat, 0, d);
        end
        @(posedge clk);
        rand_rdy = 0;
        #2 rdy = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
